nn_cls_operand_streamer: RTL and testbench
==========================================

Name: nn_cls_operand_streamer

Overview:
Initiator-side sequencer for the forward NN classification datapath. It buffers three Q6.10 feature vectors (x1, x2, x3), one weight vector and the bias, loaded by a host through a word-write port. On go it streams one feature column plus its weight per clock into the classifier, holds nn_start and the bias, waits for nn_done, then captures a1..a3 and the unhealthy flag. A watchdog flags a classifier that never completes.

Parameters:
DATA_WIDTH, 16, operand and result word width (signed Q6.10)
N_FEAT, 9, features per sample = stream length in cycles
TIMEOUT, 32, max cycles from last streamed column to nn_done before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  host write strobe
wr_sel  in  2  buffer select: 0=x1, 1=x2, 2=x3, 3=weights/bias
wr_idx  in  4  feature index 0..N_FEAT-1; with wr_sel=3, idx 15 = bias
wr_data  in  DATA_WIDTH  write data
go  in  1  start one classification (pulse)
busy  out  1  run in progress
nn_start  out  1  classifier start/enable
nn_x1j, nn_x2j, nn_x3j  out  DATA_WIDTH each  feature column j
nn_wj  out  DATA_WIDTH  weight j
nn_b1  out  DATA_WIDTH  bias
nn_done  in  1  classifier completion
nn_unhealthy  in  1  classifier decision
nn_a1, nn_a2, nn_a3  in  DATA_WIDTH each  classifier activations
res_valid  out  1  one-cycle result strobe
res_unhealthy  out  1  captured decision
res_a1, res_a2, res_a3  out  DATA_WIDTH each  captured activations
err  out  1  sticky error: timeout or protocol violation

Behaviour:
- Reset: all outputs 0, all buffer words and bias 0, FSM to IDLE, counters 0. Reset mid-run aborts immediately with no res_valid. err is cleared only by rst.
- Storage: 4 x N_FEAT words plus bias, all registers. Writes are accepted only in IDLE and ignored while busy=1. wr_idx >= N_FEAT is ignored, except idx 15 with sel 3. A write in the same cycle go is accepted is committed and used by that run.
- FSM states: IDLE, STREAM, WAIT, RESP.
- IDLE: go=1 moves to STREAM. The same edge loads column 0 onto nn_x*j/nn_wj and sets nn_start=1, busy=1, and nn_b1 to the bias. go in any other state is ignored.
- STREAM: column j is presented for exactly one cycle, j=0..N_FEAT-1 on consecutive cycles. The edge after column N_FEAT-1 zeroes nn_x*j/nn_wj and enters WAIT.
- nn_start and nn_b1 are held constant from the first column until the run ends.
- nn_done=1 during STREAM is a protocol violation: set err, ignore the pulse.
- WAIT: the watchdog counts cycles in WAIT. If nn_done=1 is sampled, capture nn_unhealthy and nn_a1..a3 into res_*, then go to RESP.
- Timeout: if the watchdog reaches TIMEOUT without nn_done, set err, pulse res_valid with res_unhealthy=1 and res_a*=0 (fail-safe), then go to RESP.
- RESP: res_valid=1 for exactly this cycle. nn_start=0, busy=0, nn_b1=0. Next state is IDLE. res_* hold their value until the next capture.
- Latency: go accepted at edge k gives the first column valid after edge k, the last column after edge k+N_FEAT-1, and nn_done sampled in WAIT at edge m gives res_valid high after edge m.
- No arithmetic is performed; words pass bit-exact, sign preserved.

Test Plan:
1. Load x1/x2/x3 = 0, w[0..8] = 0x034C, 0x064F, 0x067D, 0x048A, 0x044F, 0x03C9, 0x0563, 0x04BA, 0x069D, bias 0xF3A3; pulse go -> nn_wj shows those 9 values on 9 consecutive cycles, nn_b1=0xF3A3 and nn_start=1 throughout, then zeros.
2. Model classifier raises nn_done 5 cycles into WAIT with nn_unhealthy=0, nn_a1=0x0012 -> one-cycle res_valid, res_unhealthy=0, res_a1=0x0012, busy drops, err=0.
3. nn_done never asserted -> res_valid exactly TIMEOUT cycles after WAIT entry, res_unhealthy=1, res_a*=0, err=1 sticky across the next successful run.
4. Write x1[3]=0x7FFF in the same cycle as go, and write x1[4]=0x1234 during STREAM -> column 3 shows 0x7FFF, column 4 shows the old value, and the buffer still holds the old value afterwards.
5. Assert rst at column 5 -> next cycle all outputs 0, no res_valid, buffer zeroed. A second go pulse during WAIT is ignored.
6. nn_done pulse at column 2 -> err=1, streaming continues through column 8 unchanged.

Source files
------------

// File: rtl/nn_cls_operand_streamer.sv
// ---------------------------------------------------------------------------
// nn_cls_operand_streamer
//
// Initiator-side sequencer for the forward NN classification datapath.
// A host loads three feature vectors (x1, x2, x3), one weight vector and a
// bias through a word-write port. A go pulse streams one feature column plus
// its weight per clock into the classifier while holding nn_start and the
// bias. The block then waits for nn_done and captures the activations and the
// unhealthy decision. A watchdog turns a classifier that never completes into
// a fail-safe "unhealthy" result and a sticky error.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   wr_en/wr_sel/wr_idx/wr_data
//                            host buffer write (sel 0..2 = x1..x3,
//                            sel 3 = weights, sel 3 with idx 15 = bias)
//   go                       start one classification (pulse, IDLE only)
//   busy                     run in progress
//   nn_start, nn_b1          classifier enable and bias, held for the run
//   nn_x1j/nn_x2j/nn_x3j/nn_wj
//                            feature column j and weight j
//   nn_done/nn_unhealthy/nn_a1..nn_a3
//                            classifier completion and results
//   res_valid                one-cycle result strobe
//   res_unhealthy/res_a1..res_a3
//                            captured results, held until the next capture
//   err                      sticky: watchdog timeout or nn_done while
//                            streaming; cleared only by rst
// All operand and result words pass bit-exact (signed Q6.10, no arithmetic).
// ---------------------------------------------------------------------------
module nn_cls_operand_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_FEAT     = 9,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_sel,
  input  logic [3:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  go,
  output logic                  busy,
  output logic                  nn_start,
  output logic [DATA_WIDTH-1:0] nn_x1j,
  output logic [DATA_WIDTH-1:0] nn_x2j,
  output logic [DATA_WIDTH-1:0] nn_x3j,
  output logic [DATA_WIDTH-1:0] nn_wj,
  output logic [DATA_WIDTH-1:0] nn_b1,
  input  logic                  nn_done,
  input  logic                  nn_unhealthy,
  input  logic [DATA_WIDTH-1:0] nn_a1,
  input  logic [DATA_WIDTH-1:0] nn_a2,
  input  logic [DATA_WIDTH-1:0] nn_a3,
  output logic                  res_valid,
  output logic                  res_unhealthy,
  output logic [DATA_WIDTH-1:0] res_a1,
  output logic [DATA_WIDTH-1:0] res_a2,
  output logic [DATA_WIDTH-1:0] res_a3,
  output logic                  err
);

  localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]       LAST_COL  = 4'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WDOG_ONE  = CNT_W'(1);
  localparam logic [1:0]       SEL_WB    = 2'd3;
  localparam logic [3:0]       BIAS_IDX  = 4'd15;
  localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Operand storage: row 0..2 = x1..x3, row 3 = weights.
  logic [DATA_WIDTH-1:0] r_buf [4][N_FEAT];
  logic [DATA_WIDTH-1:0] r_bias;

  state_t                r_state;
  logic [3:0]            r_col;
  logic [CNT_W-1:0]      r_wdog;
  logic                  r_busy;
  logic                  r_start;
  logic [DATA_WIDTH-1:0] r_x1j, r_x2j, r_x3j, r_wj, r_b1;
  logic                  r_res_valid;
  logic                  r_res_unh;
  logic [DATA_WIDTH-1:0] r_res_a1, r_res_a2, r_res_a3;
  logic                  r_err;

  state_t                w_state_nxt;
  logic [3:0]            w_col_nxt;
  logic [CNT_W-1:0]      w_wdog_nxt;
  logic                  w_busy_nxt;
  logic                  w_start_nxt;
  logic [DATA_WIDTH-1:0] w_x1_nxt, w_x2_nxt, w_x3_nxt, w_w_nxt, w_b1_nxt;
  logic                  w_res_valid_nxt;
  logic                  w_res_unh_nxt;
  logic [DATA_WIDTH-1:0] w_res_a1_nxt, w_res_a2_nxt, w_res_a3_nxt;
  logic                  w_err_nxt;

  logic                  w_wr_idle;
  logic                  w_wr_feat;
  logic                  w_wr_bias;
  logic [3:0]            w_rd_idx;
  logic [DATA_WIDTH-1:0] w_col [4];
  logic [DATA_WIDTH-1:0] w_bias_fwd;

  // Host writes land only while idle; out-of-range indices are dropped.
  assign w_wr_idle = wr_en && (r_state == ST_IDLE);
  assign w_wr_feat = w_wr_idle && (wr_idx <= LAST_COL);
  assign w_wr_bias = w_wr_idle && (wr_sel == SEL_WB) && (wr_idx == BIAS_IDX);

  // Operand and bias buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < N_FEAT; i++) begin
          r_buf[s][i] <= ZERO_W;
        end
      end
      r_bias <= ZERO_W;
    end else begin
      if (w_wr_feat) begin
        r_buf[wr_sel][wr_idx] <= wr_data;
      end
      if (w_wr_bias) begin
        r_bias <= wr_data;
      end
    end
  end

  // Column to load at the next edge: column 0 when starting, else the next one.
  always_comb begin
    w_rd_idx = 4'd0;
    if ((r_state == ST_STREAM) && (r_col != LAST_COL)) begin
      w_rd_idx = r_col + 4'd1;
    end else begin
      w_rd_idx = 4'd0;
    end
  end

  // Column read with write forwarding, so a write issued together with go
  // is already visible in column 0 and in the bias of that same run.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_col[s] = r_buf[s][w_rd_idx];
      if (w_wr_feat && (wr_sel == 2'(s)) && (wr_idx == w_rd_idx)) begin
        w_col[s] = wr_data;
      end else begin
        w_col[s] = r_buf[s][w_rd_idx];
      end
    end
    if (w_wr_bias) begin
      w_bias_fwd = wr_data;
    end else begin
      w_bias_fwd = r_bias;
    end
  end

  // Next-state and next-output logic of the run sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_wdog_nxt      = r_wdog;
    w_busy_nxt      = r_busy;
    w_start_nxt     = r_start;
    w_x1_nxt        = r_x1j;
    w_x2_nxt        = r_x2j;
    w_x3_nxt        = r_x3j;
    w_w_nxt         = r_wj;
    w_b1_nxt        = r_b1;
    w_res_valid_nxt = 1'b0;
    w_res_unh_nxt   = r_res_unh;
    w_res_a1_nxt    = r_res_a1;
    w_res_a2_nxt    = r_res_a2;
    w_res_a3_nxt    = r_res_a3;
    w_err_nxt       = r_err;

    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt = ST_STREAM;
          w_col_nxt   = 4'd0;
          w_busy_nxt  = 1'b1;
          w_start_nxt = 1'b1;
          w_x1_nxt    = w_col[0];
          w_x2_nxt    = w_col[1];
          w_x3_nxt    = w_col[2];
          w_w_nxt     = w_col[3];
          w_b1_nxt    = w_bias_fwd;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_STREAM: begin
        // Completion before all operands were delivered cannot be trusted:
        // flag it and keep streaming.
        if (nn_done) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        if (r_col == LAST_COL) begin
          w_state_nxt = ST_WAIT;
          w_wdog_nxt  = {CNT_W{1'b0}};
          w_x1_nxt    = ZERO_W;
          w_x2_nxt    = ZERO_W;
          w_x3_nxt    = ZERO_W;
          w_w_nxt     = ZERO_W;
        end else begin
          w_col_nxt = r_col + 4'd1;
          w_x1_nxt  = w_col[0];
          w_x2_nxt  = w_col[1];
          w_x3_nxt  = w_col[2];
          w_w_nxt   = w_col[3];
        end
      end

      ST_WAIT: begin
        // r_wdog holds (WAIT edges seen - 1); a genuine nn_done wins over
        // the watchdog on the final allowed edge.
        if (nn_done) begin
          w_state_nxt     = ST_RESP;
          w_res_valid_nxt = 1'b1;
          w_res_unh_nxt   = nn_unhealthy;
          w_res_a1_nxt    = nn_a1;
          w_res_a2_nxt    = nn_a2;
          w_res_a3_nxt    = nn_a3;
          w_busy_nxt      = 1'b0;
          w_start_nxt     = 1'b0;
          w_b1_nxt        = ZERO_W;
          w_col_nxt       = 4'd0;
        end else if (r_wdog == WDOG_LAST) begin
          // Fail-safe: a silent classifier is reported as unhealthy.
          w_state_nxt     = ST_RESP;
          w_err_nxt       = 1'b1;
          w_res_valid_nxt = 1'b1;
          w_res_unh_nxt   = 1'b1;
          w_res_a1_nxt    = ZERO_W;
          w_res_a2_nxt    = ZERO_W;
          w_res_a3_nxt    = ZERO_W;
          w_busy_nxt      = 1'b0;
          w_start_nxt     = 1'b0;
          w_b1_nxt        = ZERO_W;
          w_col_nxt       = 4'd0;
        end else begin
          w_wdog_nxt = r_wdog + WDOG_ONE;
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
        w_wdog_nxt  = {CNT_W{1'b0}};
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= 4'd0;
      r_wdog      <= {CNT_W{1'b0}};
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_x1j       <= ZERO_W;
      r_x2j       <= ZERO_W;
      r_x3j       <= ZERO_W;
      r_wj        <= ZERO_W;
      r_b1        <= ZERO_W;
      r_res_valid <= 1'b0;
      r_res_unh   <= 1'b0;
      r_res_a1    <= ZERO_W;
      r_res_a2    <= ZERO_W;
      r_res_a3    <= ZERO_W;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_wdog      <= w_wdog_nxt;
      r_busy      <= w_busy_nxt;
      r_start     <= w_start_nxt;
      r_x1j       <= w_x1_nxt;
      r_x2j       <= w_x2_nxt;
      r_x3j       <= w_x3_nxt;
      r_wj        <= w_w_nxt;
      r_b1        <= w_b1_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_unh   <= w_res_unh_nxt;
      r_res_a1    <= w_res_a1_nxt;
      r_res_a2    <= w_res_a2_nxt;
      r_res_a3    <= w_res_a3_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign busy          = r_busy;
  assign nn_start      = r_start;
  assign nn_x1j        = r_x1j;
  assign nn_x2j        = r_x2j;
  assign nn_x3j        = r_x3j;
  assign nn_wj         = r_wj;
  assign nn_b1         = r_b1;
  assign res_valid     = r_res_valid;
  assign res_unhealthy = r_res_unh;
  assign res_a1        = r_res_a1;
  assign res_a2        = r_res_a2;
  assign res_a3        = r_res_a3;
  assign err           = r_err;

endmodule

// File: tb/tb_nn_cls_operand_streamer.sv
// ---------------------------------------------------------------------------
// Bench for nn_cls_operand_streamer. Stimulus keeps a plain array model of the
// operand buffers and, for each run, queues the expected per-cycle stream
// outputs and the expected result (tagged with the cycle they must appear in).
// A monitor on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_nn_cls_operand_streamer;
  localparam int DW = 16;
  localparam int NF = 9;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst, wr_en, go, nn_done, nn_unhealthy;
  logic [1:0]    wr_sel;
  logic [3:0]    wr_idx;
  logic [DW-1:0] wr_data, nn_a1, nn_a2, nn_a3;
  logic          busy, nn_start, res_valid, res_unhealthy, err;
  logic [DW-1:0] nn_x1j, nn_x2j, nn_x3j, nn_wj, nn_b1, res_a1, res_a2, res_a3;

  always #5 clk = ~clk;

  nn_cls_operand_streamer #(.DATA_WIDTH(DW), .N_FEAT(NF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx),
    .wr_data(wr_data), .go(go), .busy(busy), .nn_start(nn_start),
    .nn_x1j(nn_x1j), .nn_x2j(nn_x2j), .nn_x3j(nn_x3j), .nn_wj(nn_wj),
    .nn_b1(nn_b1), .nn_done(nn_done), .nn_unhealthy(nn_unhealthy),
    .nn_a1(nn_a1), .nn_a2(nn_a2), .nn_a3(nn_a3), .res_valid(res_valid),
    .res_unhealthy(res_unhealthy), .res_a1(res_a1), .res_a2(res_a2),
    .res_a3(res_a3), .err(err)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] x1, x2, x3, w, b1;
    logic          st, bz, er;
  } cyc_exp_t;

  typedef struct {
    int            cyc;
    logic          unh;
    logic [DW-1:0] a1, a2, a3;
  } res_exp_t;

  cyc_exp_t q_cyc[$];
  res_exp_t q_res[$];
  cyc_exp_t mon_c;
  res_exp_t mon_r;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: rows 0..2 = x1..x3, row 3 = weights.
  logic [DW-1:0] m_x [4][NF];
  logic [DW-1:0] m_bias;
  logic          m_err;
  logic [DW-1:0] w_init [NF] = '{16'h034C, 16'h064F, 16'h067D, 16'h048A,
                                 16'h044F, 16'h03C9, 16'h0563, 16'h04BA, 16'h069D};

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare queued expectations against the DUT on the falling edge.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0].cyc < cyc) begin
      mon_c = q_cyc.pop_front();
      n_tests++; n_fail++;
      $display("FAIL stream_missed cyc=%0d act=not_checked required_cyc=%0d", cyc, mon_c.cyc);
    end
    if (q_cyc.size() > 0 && q_cyc[0].cyc == cyc) begin
      mon_c = q_cyc.pop_front();
      n_tests++;
      if ({nn_x1j, nn_x2j, nn_x3j, nn_wj, nn_b1, nn_start, busy, err} !==
          {mon_c.x1, mon_c.x2, mon_c.x3, mon_c.w, mon_c.b1, mon_c.st, mon_c.bz, mon_c.er}) begin
        n_fail++;
        $display("FAIL stream cyc=%0d act x=%h/%h/%h w=%h b=%h st=%b bz=%b err=%b req x=%h/%h/%h w=%h b=%h st=%b bz=%b err=%b",
                 cyc, nn_x1j, nn_x2j, nn_x3j, nn_wj, nn_b1, nn_start, busy, err,
                 mon_c.x1, mon_c.x2, mon_c.x3, mon_c.w, mon_c.b1, mon_c.st, mon_c.bz, mon_c.er);
      end
    end
    while (q_res.size() > 0 && q_res[0].cyc < cyc) begin
      mon_r = q_res.pop_front();
      n_tests++; n_fail++;
      $display("FAIL res_missing cyc=%0d act=no_res_valid required_cyc=%0d", cyc, mon_r.cyc);
    end
    if (res_valid === 1'b1) begin
      n_tests++;
      if (q_res.size() == 0 || q_res[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL res_unexpected cyc=%0d act res_valid=1 required res_valid=0", cyc);
      end else begin
        mon_r = q_res.pop_front();
        if ({res_unhealthy, res_a1, res_a2, res_a3} !== {mon_r.unh, mon_r.a1, mon_r.a2, mon_r.a3}) begin
          n_fail++;
          $display("FAIL res_value cyc=%0d act unh=%b a=%h/%h/%h required unh=%b a=%h/%h/%h",
                   cyc, res_unhealthy, res_a1, res_a2, res_a3, mon_r.unh, mon_r.a1, mon_r.a2, mon_r.a3);
        end
      end
    end
  end

  function automatic cyc_exp_t mk_cyc(input int c, input logic [DW-1:0] x1, x2, x3, w, b1,
                                      input logic st, bz, er);
    cyc_exp_t r;
    r.cyc = c; r.x1 = x1; r.x2 = x2; r.x3 = x3; r.w = w; r.b1 = b1;
    r.st = st; r.bz = bz; r.er = er;
    return r;
  endfunction

  function automatic res_exp_t mk_res(input int c, input logic unh, input logic [DW-1:0] a1, a2, a3);
    res_exp_t r;
    r.cyc = c; r.unh = unh; r.a1 = a1; r.a2 = a2; r.a3 = a3;
    return r;
  endfunction

  // Model of the host write rule (applied only while no run is active).
  function automatic void model_write(input logic [1:0] s, input logic [3:0] i, input logic [DW-1:0] d);
    if (int'(i) < NF) m_x[s][i] = d;
    else if (s == 2'd3 && i == 4'd15) m_bias = d;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 4; s++) for (int i = 0; i < NF; i++) m_x[s][i] = '0;
    m_bias = '0;
    m_err  = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] s, input logic [3:0] i, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = s; wr_idx = i; wr_data = d;
    tick();
    wr_en = 1'b0;
    model_write(s, i, d);
  endtask

  // One classification. d = number of idle WAIT cycles before nn_done
  // (-1: never, watchdog expires). done_col/stream_wr_col/rst_col = column at
  // which that disturbance is applied (-1: none).
  task automatic run(input int done_col, input int stream_wr_col, input int rst_col,
                     input bit go_wr, input bit go_in_wait, input int d,
                     input logic unh, input logic [DW-1:0] a1, a2, a3);
    int k, e, m;
    logic err0;
    go = 1'b1;
    if (go_wr) begin
      wr_en = 1'b1; wr_sel = 2'd0; wr_idx = 4'd3; wr_data = 16'h7FFF;
      model_write(2'd0, 4'd3, 16'h7FFF);
    end
    tick();
    go = 1'b0; wr_en = 1'b0;
    k = cyc; e = k + NF; m = (d < 0) ? e + TO : e + d + 1;
    err0 = m_err;
    for (int j = 0; j < NF; j++)
      q_cyc.push_back(mk_cyc(k + j, m_x[0][j], m_x[1][j], m_x[2][j], m_x[3][j], m_bias,
                             1'b1, 1'b1, err0 | (done_col >= 0 && j > done_col)));
    for (int c = e; c < m; c++)
      q_cyc.push_back(mk_cyc(c, '0, '0, '0, '0, m_bias, 1'b1, 1'b1, err0 | (done_col >= 0)));
    if (done_col >= 0 || d < 0) m_err = 1'b1;
    q_cyc.push_back(mk_cyc(m,     '0, '0, '0, '0, '0, 1'b0, 1'b0, m_err));
    q_cyc.push_back(mk_cyc(m + 1, '0, '0, '0, '0, '0, 1'b0, 1'b0, m_err));
    if (d < 0) q_res.push_back(mk_res(m, 1'b1, '0, '0, '0));
    else       q_res.push_back(mk_res(m, unh, a1, a2, a3));

    for (int j = 0; j < NF; j++) begin
      if (j == rst_col) begin
        while (q_cyc.size() > 0 && q_cyc[$].cyc > cyc) void'(q_cyc.pop_back());
        q_res.delete();
        q_cyc.push_back(mk_cyc(cyc + 1, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0));
        model_clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      if (j == done_col) begin
        nn_done = 1'b1; nn_unhealthy = 1'($urandom);
      end
      if (j == stream_wr_col) begin
        wr_en = 1'b1; wr_sel = 2'd0; wr_idx = 4'd4; wr_data = 16'h1234;
      end
      tick();
      nn_done = 1'b0; wr_en = 1'b0;
    end

    if (d < 0) begin
      for (int i = 0; i < TO; i++) begin
        if (go_in_wait && i == 0) go = 1'b1;
        tick();
        go = 1'b0;
      end
    end else begin
      for (int i = 0; i < d; i++) begin
        if (go_in_wait && i == 0) go = 1'b1;
        tick();
        go = 1'b0;
      end
      nn_done = 1'b1; nn_unhealthy = unh; nn_a1 = a1; nn_a2 = a2; nn_a3 = a3;
      tick();
      nn_done = 1'b0; nn_unhealthy = 1'($urandom);
      nn_a1 = 16'($urandom); nn_a2 = 16'($urandom); nn_a3 = 16'($urandom);
    end
    tick();
  endtask

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL tb_watchdog act=still_running required=finished");
    $fatal(1, "bench time limit");
  end

  // Stimulus.
  initial begin
    int dd;
    rst = 1'b1; wr_en = 1'b0; go = 1'b0; nn_done = 1'b0; nn_unhealthy = 1'b0;
    wr_sel = '0; wr_idx = '0; wr_data = '0;
    nn_a1 = 16'($urandom); nn_a2 = 16'($urandom); nn_a3 = 16'($urandom);
    model_clear();
    tick();
    q_cyc.push_back(mk_cyc(cyc + 1, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0));
    tick();
    rst = 1'b0;

    // Known weights/bias, zero features; classifier answers 5 cycles into WAIT.
    for (int j = 0; j < NF; j++) begin
      do_write(2'd0, 4'(j), '0);
      do_write(2'd1, 4'(j), '0);
      do_write(2'd2, 4'(j), '0);
      do_write(2'd3, 4'(j), w_init[j]);
    end
    do_write(2'd3, 4'd15, 16'hF3A3);
    run(-1, -1, -1, 1'b0, 1'b0, 4, 1'b0, 16'h0012, 16'h0000, 16'h0000);
    run(-1, -1, -1, 1'b0, 1'b0, 0, 1'b1, 16'h8001, 16'h7FFF, 16'hFFFF);

    // nn_done while streaming: error, stream unaffected.
    run(2, -1, -1, 1'b0, 1'b0, 3, 1'b0, 16'h1111, 16'h2222, 16'h3333);

    // Reset at column 5 clears everything; next run streams zeros, go in WAIT ignored.
    run(-1, -1, 5, 1'b0, 1'b0, 2, 1'b0, 16'h0, 16'h0, 16'h0);
    run(-1, -1, -1, 1'b0, 1'b1, 7, 1'b1, 16'hA5A5, 16'h5A5A, 16'h0F0F);

    // Write with go is used; write during stream is ignored (checked by the follow-up run).
    for (int j = 0; j < NF; j++) do_write(2'd0, 4'(j), 16'($urandom));
    do_write(2'd1, 4'd9, 16'hDEAD);
    do_write(2'd2, 4'd15, 16'hBEEF);
    run(-1, 4, -1, 1'b1, 1'b0, 2, 1'b0, 16'h0042, 16'h0043, 16'h0044);
    run(-1, -1, -1, 1'b0, 1'b0, 1, 1'b0, 16'h0001, 16'h0002, 16'h0003);

    // Watchdog expiry, then a done on the last allowed cycle with err still sticky.
    run(-1, -1, -1, 1'b0, 1'b1, -1, 1'b0, 16'h0, 16'h0, 16'h0);
    run(-1, -1, -1, 1'b0, 1'b0, TO - 1, 1'b0, 16'h1357, 16'h2468, 16'h9ABC);

    // Randomized buffers and classifier timing.
    repeat (6) begin
      repeat (12) do_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
      dd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run(-1, -1, -1, 1'b0, 1'b0, dd, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    repeat (4) tick();
    n_tests++;
    if (q_cyc.size() != 0 || q_res.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained act=%0d/%0d required=0/0", q_cyc.size(), q_res.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
